// File: rtl/timer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the timer sequencer slice.
//   TIMER_WIDTH   : default counter/period width
//   timer_state_t : sequencer FSM states (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam int TIMER_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/timer_sequencer_if.sv
// ---------------------------------------------------------------------------
// timer_sequencer_if
// Command/status bundle between control logic and the timer sequencer.
// Signal directions are named from the sequencer's point of view.
//   start_i  : single-cycle (re)start command
//   stop_i   : single-cycle abort command
//   mode_i   : 0 = one-shot, 1 = periodic (sampled on start)
//   period_i : terminal count (sampled on start)
//   count_o  : current counter value
//   busy_o   : high while running
//   tick_o   : one-cycle pulse per terminal count
//   done_o   : sticky one-shot completion flag
// Modports: master = control logic, slave = sequencer.
// ---------------------------------------------------------------------------
interface timer_sequencer_if
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) ();

    logic             start_i;
    logic             stop_i;
    logic             mode_i;
    logic [WIDTH-1:0] period_i;
    logic [WIDTH-1:0] count_o;
    logic             busy_o;
    logic             tick_o;
    logic             done_o;

    modport master (
        output start_i, stop_i, mode_i, period_i,
        input  count_o, busy_o, tick_o, done_o
    );

    modport slave (
        input  start_i, stop_i, mode_i, period_i,
        output count_o, busy_o, tick_o, done_o
    );

endinterface

// File: rtl/timer_sequencer_count_core.sv
// ---------------------------------------------------------------------------
// count_core
// Plain WIDTH-bit up-counter with synchronous clear and async active-low
// reset. Clear wins over enable.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   en_i    : increment enable
//   clr_i   : synchronous clear to zero
//   count_o : registered counter value
// ---------------------------------------------------------------------------
module count_core
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear takes priority, otherwise step when enabled.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/timer_sequencer.sv
// ---------------------------------------------------------------------------
// timer_sequencer
// Runs a shared up-counter as a programmable one-shot or periodic timer.
// Latches period/mode on start, emits a registered tick at each terminal
// count and a sticky done when a one-shot completes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : timer_sequencer_if.slave (commands in, count/status out)
// ---------------------------------------------------------------------------
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    timer_sequencer_if.slave   bus
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] countVal;
    logic             countEn;
    logic             countClr;
    logic             termCount;
    logic             acceptStart;

    // Stop outranks start, so a simultaneous pair never counts as a start.
    assign acceptStart = bus.start_i && !bus.stop_i;
    assign termCount   = (state_q == RUN) && (countVal == period_q);

    count_core #(
        .WIDTH (WIDTH)
    ) u_count_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (countEn),
        .clr_i   (countClr),
        .count_o (countVal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: stop, then start, then terminal-count handling.
    always_comb begin
        state_d = state_q;
        if (bus.stop_i) begin
            state_d = IDLE;
        end else if (bus.start_i) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (termCount && !mode_q) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Output/datapath control. In one-shot the counter simply stops at the
    // terminal count (no enable, no clear), which holds it at period_q.
    always_comb begin
        countEn  = 1'b0;
        countClr = 1'b0;
        tick_d   = 1'b0;
        done_d   = done_q;
        period_d = period_q;
        mode_d   = mode_q;
        if (bus.stop_i) begin
            countClr = 1'b1;
            done_d   = 1'b0;
        end else if (bus.start_i) begin
            countClr = 1'b1;
            done_d   = 1'b0;
        end else if (state_q == RUN) begin
            if (termCount) begin
                tick_d = 1'b1;
                if (mode_q) begin
                    countClr = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end else begin
                countEn = 1'b1;
            end
        end else if (state_q == IDLE) begin
            countClr = 1'b1;
        end
        if (acceptStart) begin
            period_d = bus.period_i;
            mode_d   = bus.mode_i;
        end
    end

    // Latched configuration and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    assign bus.count_o = countVal;
    assign bus.busy_o  = (state_q == RUN);
    assign bus.tick_o  = tick_q;
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_timer_sequencer
// Directed self-checking bench for timer_sequencer. Outputs are sampled on
// the falling edge; inputs are changed on the falling edge as well.
// ---------------------------------------------------------------------------
module tb_timer_sequencer;

    logic clk;
    logic rst_n;
    int   totalCount;
    int   badCount;
    int   expCount;

    timer_sequencer_if #(.WIDTH(8)) bus ();

    timer_sequencer #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one active edge and land on the following falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one command for a single edge, then drop the pulses.
    task automatic applyStimulus(input logic start, input logic stop,
                                 input logic mode, input logic [7:0] period);
        bus.start_i  = start;
        bus.stop_i   = stop;
        bus.mode_i   = mode;
        bus.period_i = period;
        cycle();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
    endtask

    // Periodic reference: count walks 0..p then wraps, tick on each wrap.
    task automatic runPeriodic(input int p, input int n, input string tag);
        logic expTick;
        for (int i = 0; i < n; i++) begin
            expTick  = (expCount == p);
            expCount = (expCount == p) ? 0 : expCount + 1;
            cycle();
            checkOutput({tag, "_count"}, 32'(bus.count_o), 32'(expCount));
            checkOutput({tag, "_tick"}, 32'(bus.tick_o), 32'(expTick));
            checkOutput({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
        end
    endtask

    // Hand-computed sequence for the first periodic test (P=3).
    logic [7:0] p3Count [8] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    logic       p3Tick  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        totalCount   = 0;
        badCount     = 0;
        expCount     = 0;
        rst_n        = 1'b0;
        bus.start_i  = 1'b0;
        bus.stop_i   = 1'b0;
        bus.mode_i   = 1'b0;
        bus.period_i = 8'd0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_count", 32'(bus.count_o), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("rst_tick", 32'(bus.tick_o), 32'd0);
        checkOutput("rst_done", 32'(bus.done_o), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Periodic P=3.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3);
        checkOutput("p3_start_count", 32'(bus.count_o), 32'd0);
        checkOutput("p3_start_busy", 32'(bus.busy_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cycle();
            checkOutput("p3_count", 32'(bus.count_o), 32'(p3Count[i]));
            checkOutput("p3_tick", 32'(bus.tick_o), 32'(p3Tick[i]));
            checkOutput("p3_busy", 32'(bus.busy_o), 32'd1);
        end

        // One-shot P=5.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd5);
        checkOutput("os_start_count", 32'(bus.count_o), 32'd0);
        checkOutput("os_start_tick", 32'(bus.tick_o), 32'd0);
        for (int j = 1; j <= 5; j++) begin
            cycle();
            checkOutput("os_count", 32'(bus.count_o), 32'(j));
            checkOutput("os_busy", 32'(bus.busy_o), 32'd1);
            checkOutput("os_tick", 32'(bus.tick_o), 32'd0);
            checkOutput("os_done", 32'(bus.done_o), 32'd0);
        end
        cycle();
        checkOutput("os_end_count", 32'(bus.count_o), 32'd5);
        checkOutput("os_end_tick", 32'(bus.tick_o), 32'd1);
        checkOutput("os_end_done", 32'(bus.done_o), 32'd1);
        checkOutput("os_end_busy", 32'(bus.busy_o), 32'd0);
        for (int j = 0; j < 3; j++) begin
            cycle();
            checkOutput("os_hold_count", 32'(bus.count_o), 32'd5);
            checkOutput("os_hold_tick", 32'(bus.tick_o), 32'd0);
            checkOutput("os_hold_done", 32'(bus.done_o), 32'd1);
            checkOutput("os_hold_busy", 32'(bus.busy_o), 32'd0);
        end

        // Periodic P=0, started from DONE (clears done).
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd0);
        checkOutput("p0_start_done", 32'(bus.done_o), 32'd0);
        checkOutput("p0_start_busy", 32'(bus.busy_o), 32'd1);
        checkOutput("p0_start_tick", 32'(bus.tick_o), 32'd0);
        expCount = 0;
        runPeriodic(0, 5, "p0");

        // Stop beats the terminal count; start+stop together ends in IDLE.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd4);
        expCount = 0;
        runPeriodic(4, 4, "p4");
        checkOutput("p4_at_term", 32'(bus.count_o), 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd4);
        checkOutput("stop_tick", 32'(bus.tick_o), 32'd0);
        checkOutput("stop_count", 32'(bus.count_o), 32'd0);
        checkOutput("stop_busy", 32'(bus.busy_o), 32'd0);
        cycle();
        checkOutput("stop_after_tick", 32'(bus.tick_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd4);
        cycle();
        cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd4);
        checkOutput("both_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("both_count", 32'(bus.count_o), 32'd0);
        checkOutput("both_done", 32'(bus.done_o), 32'd0);
        checkOutput("both_tick", 32'(bus.tick_o), 32'd0);

        // Reprogramming mid-RUN is ignored; restart at the terminal count
        // suppresses that tick and picks up the new period.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3);
        expCount = 0;
        runPeriodic(3, 2, "rp_a");
        bus.period_i = 8'd7;
        runPeriodic(3, 13, "rp_b");
        checkOutput("rp_pre_restart", 32'(bus.count_o), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd7);
        checkOutput("rp_restart_count", 32'(bus.count_o), 32'd0);
        checkOutput("rp_restart_tick", 32'(bus.tick_o), 32'd0);
        expCount = 0;
        runPeriodic(7, 16, "rp_c");

        // Asynchronous reset mid-RUN, then full-range periodic count.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3);
        expCount = 0;
        runPeriodic(3, 2, "ar_pre");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_count", 32'(bus.count_o), 32'd0);
        checkOutput("ar_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("ar_tick", 32'(bus.tick_o), 32'd0);
        checkOutput("ar_done", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkOutput("ar_idle_count", 32'(bus.count_o), 32'd0);
            checkOutput("ar_idle_busy", 32'(bus.busy_o), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd255);
        checkOutput("fr_start_busy", 32'(bus.busy_o), 32'd1);
        expCount = 0;
        runPeriodic(255, 255, "fr_up");
        checkOutput("fr_top", 32'(bus.count_o), 32'd255);
        runPeriodic(255, 2, "fr_wrap");

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
